// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and
// instruction-size constants.
package fetch_pkg;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO. Flush wins over push/pop; dout shows the head
// entry straight from storage.
module fetch_queue #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // The upstream credit rule must never let a word arrive at a full queue.
  always @(posedge clk) begin
    if (reset && !flush) assert (!(push && full && !pop));
  end

endmodule

// File: rtl/fetch_unit.sv
// Pipelined fetch stage: sequential PC, one-cycle imem read, prefetch queue
// feeding decode over valid/ready, with redirect flushing queue and in-flight read.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus_4,
  output fetch_state_e       fsm_state
);

  // Handshake: a head entry moves to decode on the rising edge where
  // id_valid && id_ready; id_valid never depends on id_ready.
  localparam int                CW   = $clog2(QDEPTH) + 1;
  localparam int                EW   = INSTR_W + 2 * ADDR_W;
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              inflight;
  logic              kill;
  logic              issue;
  logic [CW:0]       credit;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic [EW-1:0]     q_din;
  logic [EW-1:0]     q_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH_BOOT: state_nxt = FETCH_RUN;
      FETCH_RUN:  state_nxt = FETCH_RUN;
      default:    state_nxt = FETCH_BOOT;
    endcase
  end

  // Outstanding read counts against the queue so its response always has a slot.
  always_comb begin
    credit = {1'b0, count} + {{CW{1'b0}}, inflight};
    issue  = 1'b0;
    if (state == FETCH_RUN && !redirect_valid) issue = (credit < (CW + 1)'(QDEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      resp_pc  <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= redirect_valid && inflight;
      if (redirect_valid)  pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (issue)      pc <= pc + STEP;
      if (issue) resp_pc <= pc;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = pc;
  assign push      = inflight && !kill;
  assign pop       = id_valid && id_ready;
  assign q_din     = {imem_rdata, resp_pc, resp_pc + STEP};
  assign id_valid  = !empty;
  assign fsm_state = state;
  assign {id_instr, id_pc, id_pc_plus_4} = q_dout;

  fetch_queue #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (q_din),
    .dout  (q_dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule
